rocketcpu_wb_initiator: RTL and testbench

Wishbone bus initiator that turns single read/write commands from a simple valid/ready command port into classic Wishbone cycles. It returns read data or an error through a valid/ready response port. It sits between a sequencing engine (audio parameter loader, debug bridge) and the same Wishbone fabric that serves the CPU peripheral register blocks. A per-cycle timeout guarantees a response even when no responder acknowledges.

---
 rtl/rocketcpu_wb_pkg.sv | 15 +
 rtl/rocketcpu_wb_timeout.sv | 40 ++++
 rtl/rocketcpu_wb_initiator.sv | 152 +++++++++++++++
 tb/tb_rocketcpu_wb_initiator.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rocketcpu_wb_pkg.sv
// Shared types and constants for the Wishbone command initiator and its benches.
package rocketcpu_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

    localparam int          TIMEOUT_DEFAULT  = 256;
    localparam int          CNT_W            = 16;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
    localparam logic [31:0] AUDIO_BASE       = 32'h1000_0000;

endpackage

// File: rtl/rocketcpu_wb_timeout.sv
// Saturating 16-bit bus-cycle counter; expired flags the last permitted cycle of a Wishbone cycle.
module rocketcpu_wb_timeout
    import rocketcpu_wb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic i_wb_clk,
    input  logic i_wb_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_enable && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter holds the index of the current BUS cycle, so LIMIT marks cycle number TIMEOUT.
    assign o_expired = (cnt_q >= LIMIT);

endmodule

// File: rtl/rocketcpu_wb_initiator.sv
// Single-outstanding Wishbone classic initiator: valid/ready command in, valid/ready response out.
module rocketcpu_wb_initiator
    import rocketcpu_wb_pkg::*;
#(
    parameter int          TIMEOUT  = TIMEOUT_DEFAULT,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_we,
    input  logic [31:0] i_cmd_adr,
    input  logic [31:0] i_cmd_dat,
    input  logic [3:0]  i_cmd_sel,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_dat,
    output logic        o_rsp_err,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack
);

    wb_state_e   state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rsp_err_q, rsp_err_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;

    logic        tmr_clear;
    logic        tmr_enable;
    logic        tmr_expired;

    rocketcpu_wb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_wb_clk   (i_wb_clk),
        .i_wb_rst_n (i_wb_rst_n),
        .i_clear    (tmr_clear),
        .i_enable   (tmr_enable),
        .o_expired  (tmr_expired)
    );

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        tmr_clear   = 1'b0;
        tmr_enable  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    we_d        = i_cmd_we;
                    adr_d       = i_cmd_adr;
                    dat_d       = i_cmd_dat;
                    sel_d       = i_cmd_sel;
                    tmr_clear   = 1'b1;
                    cyc_d       = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = ST_BUS;
                end
            end
            ST_BUS: begin
                tmr_enable = 1'b1;
                // Ack is checked first so a same-cycle ack beats the timeout.
                if (i_wb_ack) begin
                    rsp_dat_d   = we_q ? 32'h0 : i_wb_rdt;
                    rsp_err_d   = 1'b0;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (tmr_expired) begin
                    rsp_dat_d   = we_q ? 32'h0 : ERR_DATA;
                    rsp_err_d   = 1'b1;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
        end
    end

    assign o_cmd_ready = cmd_ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_dat   = rsp_dat_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = cyc_q;
    assign o_wb_we     = we_q;
    assign o_wb_adr    = adr_q;
    assign o_wb_dat    = dat_q;
    assign o_wb_sel    = sel_q;

endmodule

// File: tb/tb_rocketcpu_wb_initiator.sv
// Directed bench for rocketcpu_wb_initiator with TIMEOUT=8 and a hand-driven responder.
module tb_rocketcpu_wb_initiator;
    import rocketcpu_wb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic [31:0] wb_rdt;
    logic        wb_ack;

    int total;
    int bad;

    rocketcpu_wb_initiator #(
        .TIMEOUT  (8),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .i_wb_clk    (clk),
        .i_wb_rst_n  (rst_n),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_we    (cmd_we),
        .i_cmd_adr   (cmd_adr),
        .i_cmd_dat   (cmd_dat),
        .i_cmd_sel   (cmd_sel),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_dat   (rsp_dat),
        .o_rsp_err   (rsp_err),
        .o_wb_cyc    (wb_cyc),
        .o_wb_stb    (wb_stb),
        .o_wb_we     (wb_we),
        .o_wb_adr    (wb_adr),
        .o_wb_dat    (wb_dat),
        .o_wb_sel    (wb_sel),
        .i_wb_rdt    (wb_rdt),
        .i_wb_ack    (wb_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
        chk({tag, "_cyc"}, 32'(wb_cyc), 32'd1);
        chk({tag, "_stb"}, 32'(wb_stb), 32'd1);
        chk({tag, "_we"},  32'(wb_we),  32'(we));
        chk({tag, "_adr"}, wb_adr, adr);
        chk({tag, "_dat"}, wb_dat, dat);
        chk({tag, "_sel"}, 32'(wb_sel), 32'(sel));
        chk({tag, "_rdy"}, 32'(cmd_ready), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"},  32'(cmd_ready), 32'd1);
        chk({tag, "_rv"},   32'(rsp_valid), 32'd0);
        chk({tag, "_err"},  32'(rsp_err),   32'd0);
        chk({tag, "_rdat"}, rsp_dat,        32'd0);
        chk({tag, "_cyc"},  32'(wb_cyc),    32'd0);
        chk({tag, "_stb"},  32'(wb_stb),    32'd0);
        chk({tag, "_we"},   32'(wb_we),     32'd0);
        chk({tag, "_adr"},  wb_adr,         32'd0);
        chk({tag, "_dat"},  wb_dat,         32'd0);
        chk({tag, "_sel"},  32'(wb_sel),    32'd0);
    endtask

    initial begin
        int cyc_cnt;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        cmd_dat   = '0;
        cmd_sel   = '0;
        rsp_ready = 1'b0;
        wb_rdt    = '0;
        wb_ack    = 1'b0;

        // Reset state
        tick();
        tick();
        chk_reset_vals("reset");
        #2 rst_n = 1'b1;
        tick();
        chk_reset_vals("post_reset");
        $display("txn reset: checked reset values");

        // Write, ack two cycles after cyc rises; command fields change after accept
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = AUDIO_BASE + 32'h8;
        cmd_dat   = 32'h0000_1234;
        cmd_sel   = 4'hF;
        tick();
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = 32'hFFFF_FFF0;
        cmd_dat   = 32'hAAAA_AAAA;
        cmd_sel   = 4'h1;
        chk_bus("wr_bus0", 1'b1, 32'h1000_0008, 32'h0000_1234, 4'hF);
        tick();
        chk_bus("wr_bus1", 1'b1, 32'h1000_0008, 32'h0000_1234, 4'hF);
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        chk("wr_cyc_low", 32'(wb_cyc), 32'd0);
        chk("wr_rv", 32'(rsp_valid), 32'd1);
        chk("wr_err", 32'(rsp_err), 32'd0);
        chk("wr_rdat", rsp_dat, 32'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("wr_done_rv", 32'(rsp_valid), 32'd0);
        chk("wr_done_rdy", 32'(cmd_ready), 32'd1);
        $display("txn write adr=%h rsp_dat=%h err=%0d", 32'h1000_0008, 32'd0, 0);

        // Read with ack on the first BUS cycle
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = AUDIO_BASE + 32'h4;
        tick();
        cmd_valid = 1'b0;
        chk("rd_cyc", 32'(wb_cyc), 32'd1);
        chk("rd_adr", wb_adr, 32'h1000_0004);
        chk("rd_we", 32'(wb_we), 32'd0);
        wb_ack = 1'b1;
        wb_rdt = 32'hCAFE_0001;
        tick();
        wb_ack = 1'b0;
        wb_rdt = 32'h0;
        chk("rd_rv", 32'(rsp_valid), 32'd1);
        chk("rd_rdat", rsp_dat, 32'hCAFE_0001);
        chk("rd_err", 32'(rsp_err), 32'd0);
        tick();
        chk("rd_hold_rdat", rsp_dat, 32'hCAFE_0001);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rd_done_rdy", 32'(cmd_ready), 32'd1);
        $display("txn read adr=%h rsp_dat=%h err=%0d", 32'h1000_0004, 32'hCAFE_0001, 0);

        // Timeout: no ack, cyc must stay high exactly 8 cycles
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = AUDIO_BASE + 32'hC;
        tick();
        cmd_valid = 1'b0;
        cyc_cnt = 0;
        while (wb_cyc === 1'b1 && cyc_cnt < 20) begin
            cyc_cnt++;
            tick();
        end
        chk("to_cyc_cycles", 32'(cyc_cnt), 32'd8);
        chk("to_rv", 32'(rsp_valid), 32'd1);
        chk("to_err", 32'(rsp_err), 32'd1);
        chk("to_rdat", rsp_dat, 32'hDEAD_BEEF);
        wb_ack = 1'b1;
        wb_rdt = 32'h1111_2222;
        tick();
        wb_ack = 1'b0;
        chk("to_late_ack_rdat", rsp_dat, 32'hDEAD_BEEF);
        chk("to_late_ack_err", 32'(rsp_err), 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        tick();
        chk("to_no_second_rsp", 32'(rsp_valid), 32'd0);
        chk("to_idle_cyc", 32'(wb_cyc), 32'd0);
        chk("to_idle_rdy", 32'(cmd_ready), 32'd1);
        $display("txn timeout read cycles=%0d rsp_dat=%h err=1", cyc_cnt, 32'hDEAD_BEEF);

        // Ack arrives on the 8th BUS cycle, same cycle as timeout
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = AUDIO_BASE + 32'h10;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("col_cyc_still_high", 32'(wb_cyc), 32'd1);
        wb_ack = 1'b1;
        wb_rdt = 32'h0000_0055;
        tick();
        wb_ack = 1'b0;
        wb_rdt = 32'h0;
        chk("col_rv", 32'(rsp_valid), 32'd1);
        chk("col_err", 32'(rsp_err), 32'd0);
        chk("col_rdat", rsp_dat, 32'h0000_0055);
        $display("txn collision rsp_dat=%h err=0", 32'h55);

        // Backpressure on the pending collision response, with a competing command
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = AUDIO_BASE + 32'h20;
        cmd_dat   = 32'h7777_7777;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_rv", 32'(rsp_valid), 32'd1);
            chk("bp_rdat", rsp_dat, 32'h0000_0055);
            chk("bp_err", 32'(rsp_err), 32'd0);
            chk("bp_rdy", 32'(cmd_ready), 32'd0);
            chk("bp_cyc", 32'(wb_cyc), 32'd0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_after_rdy", 32'(cmd_ready), 32'd1);
        chk("bp_after_rv", 32'(rsp_valid), 32'd0);
        chk("bp_after_cyc", 32'(wb_cyc), 32'd0);
        $display("txn backpressure held 10 cycles, released");

        // Asynchronous reset while cyc is high
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = AUDIO_BASE + 32'h30;
        cmd_dat   = 32'h0BAD_F00D;
        cmd_sel   = 4'h3;
        tick();
        cmd_valid = 1'b0;
        chk("rst_pre_cyc", 32'(wb_cyc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_cyc", 32'(wb_cyc), 32'd0);
        chk_reset_vals("rst_async");
        tick();
        #2 rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk_reset_vals("rst_release");
        $display("txn reset mid-bus: cyc dropped, no response");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
